sd_deser_fifo_check: RTL and testbench
======================================

Name: sd_deser_fifo_check

Overview:
- Receive-side path: collapses a narrow segmented stream (srdy/drdy handshake, end-of-frame flag) back into full-width words.
- Words are buffered in a DEPTH-entry tail-write FIFO.
- An in-line sequence checker drains the FIFO under a programmable ready pattern and counts in-order versus out-of-order words.
- Sits downstream of the serializer/link and terminates the stream.

Parameters:
- PARA_WIDTH, 9: reassembled word width.
- SER_WIDTH, 4: segment width.
- DEPTH, 7: FIFO entries. Any value ≥2; need not be a power of 2.
- Derived NSEG = ceil(PARA_WIDTH/SER_WIDTH).
- Derived USZ = clog2(DEPTH+1).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- c_srdy  in  1  segment valid.
- c_drdy  out  1  segment accepted.
- c_data  in  SER_WIDTH  segment payload.
- c_ef  in  1  last segment of word.
- drdy_pat  in  8  checker ready pattern.
- usage  out  USZ  FIFO occupancy.
- ok_cnt  out  16  in-sequence words received.
- err_cnt  out  16  out-of-sequence words received.
- err  out  1  one-cycle pulse per mismatch.

Behaviour:
- Reset (reset low, async) clears: segment index, word register, word_valid, FIFO pointers, usage, pattern index, expected value, ok_cnt, err_cnt, err.
- Transfer rule: a transfer occurs on a rising edge where srdy & drdy, on every interface.

Deserializer:
- Segment index seg (0..NSEG-1), starting at 0.
- Segment k is written to word bits [k*SER_WIDTH +: SER_WIDTH], truncated at PARA_WIDTH. Segment 0 is the least-significant segment.
- On transfer with c_ef=1: the word completes, word_valid is set, seg returns to 0.
- Bits of segments not received (early ef) read as 0. The word register is cleared at the start of each word.
- Segments beyond NSEG without ef are accepted and discarded; seg saturates at NSEG-1.
- c_drdy = !word_valid | fifo_write. The next word's first segment may be accepted in the cycle the held word enters the FIFO.
- Latency: the word is offered to the FIFO the cycle after the ef segment.

FIFO (tail-write):
- Write when word_valid & (usage != DEPTH).
- Storage is registered. There is no empty bypass: a written word is visible to the checker on the following cycle.
- Output valid = (usage != 0). Output data = mem[rd_ptr].
- Read on checker transfer.
- Pointers wrap from DEPTH-1 to 0.
- Simultaneous read and write: usage unchanged.
- When full, no write occurs even if a read happens that cycle.

Checker:
- pidx advances 0..7, wrapping, every cycle.
- Checker ready = drdy_pat[pidx].
- On each transfer, compare the received word to expected:
  - Equal: ok_cnt++, expected++.
  - Not equal: err_cnt++, err=1 for one cycle, expected = data+1 (resync).
- Expected wraps modulo 2^PARA_WIDTH.
- Counters saturate at 0xFFFF.

Test Plan:
1. Send words 0..99 as 3 segments each (ef on 3rd), drdy_pat=FF -> ok_cnt=100, err_cnt=0, err never asserted, usage ≤1 throughout.
2. drdy_pat=00 while sending 9 words:
   - usage reaches 7 and the 8th word is held in the deserializer; c_drdy stays low after its ef.
   - Then drdy_pat=FF -> all drain in order, ok_cnt=9, usage returns to 0.
3. Send words 0,1,5,6 -> err pulses once at word 5; final ok_cnt=3, err_cnt=1.
4. Segments 0x5, 0xA, 0x1 (ef on 3rd) as the first word -> checker sees 0x1A5: mismatch, err_cnt=1, next expected 0x1A6. Then a single segment 0x3 with ef -> word 0x003 (upper bits zero).
5. Assert reset after 2 segments of a word:
   - usage=0, counters=0, seg=0 immediately (async).
   - After release, word 0 sent as 3 segments -> ok_cnt=1.
6. drdy_pat=A5, words 505..515 after resyncing at 505 -> wrap 511→0 accepted as in order; err_cnt=1 (initial resync only), ok_cnt=10.

Source files
------------

// File: rtl/sd_deser_fifo_check.sv
`default_nettype none
// ============================================================================
//  Module   : sd_deser_fifo_check
//  Brief    : Segment deserializer into a DEPTH-entry FIFO, drained by an
//             in-order sequence checker with a programmable ready pattern.
//  Revision : 1.0 - initial release
// ============================================================================
module sd_deser_fifo_check #(
    parameter  int PARA_WIDTH = 9,
    parameter  int SER_WIDTH  = 4,
    parameter  int DEPTH      = 7,
    localparam int USZ        = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 c_srdy,
    output logic                 c_drdy,
    input  logic [SER_WIDTH-1:0] c_data,
    input  logic                 c_ef,
    input  logic [7:0]           drdy_pat,
    output logic [USZ-1:0]       usage,
    output logic [15:0]          ok_cnt,
    output logic [15:0]          err_cnt,
    output logic                 err
);

    localparam int NSEG = (PARA_WIDTH + SER_WIDTH - 1) / SER_WIDTH;
    localparam int SEGW = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam int PTRW = $clog2(DEPTH);
    localparam logic [SEGW-1:0] SEG_LAST   = SEGW'(NSEG - 1);
    localparam logic [PTRW-1:0] PTR_LAST   = PTRW'(DEPTH - 1);
    localparam logic [USZ-1:0]  USAGE_FULL = USZ'(DEPTH);

    logic [SEGW-1:0]       r_seg;
    logic                  r_seg_sat;
    logic [PARA_WIDTH-1:0] r_word;
    logic [PARA_WIDTH-1:0] w_word_next;
    logic                  r_word_valid;

    logic [PARA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTRW-1:0]       r_wr_ptr;
    logic [PTRW-1:0]       r_rd_ptr;
    logic [USZ-1:0]        r_usage;

    logic [2:0]            r_pidx;
    logic [PARA_WIDTH-1:0] r_expected;
    logic [15:0]           r_ok_cnt;
    logic [15:0]           r_err_cnt;
    logic                  r_err;

    logic                  w_seg_xfer;
    logic                  w_fifo_wr;
    logic                  w_fifo_rd;
    logic [PARA_WIDTH-1:0] w_rd_data;

    assign w_fifo_wr  = r_word_valid && (r_usage != USAGE_FULL);
    assign c_drdy     = !r_word_valid || w_fifo_wr;
    assign w_seg_xfer = c_srdy && c_drdy;
    assign w_rd_data  = r_mem[r_rd_ptr];
    assign w_fifo_rd  = (r_usage != '0) && drdy_pat[r_pidx];

    // First segment of a word clears the rest; once saturated, segments are dropped.
    always_comb begin
        w_word_next = r_word;
        for (int i = 0; i < PARA_WIDTH; i++) begin
            if (!r_seg_sat && ((i / SER_WIDTH) == int'(r_seg)))
                w_word_next[i] = c_data[i % SER_WIDTH];
            else if (!r_seg_sat && (r_seg == '0))
                w_word_next[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_seg        <= '0;
            r_seg_sat    <= 1'b0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else begin
            if (w_seg_xfer) begin
                r_word <= w_word_next;
                if (c_ef) begin
                    r_seg     <= '0;
                    r_seg_sat <= 1'b0;
                end else if (r_seg == SEG_LAST) begin
                    r_seg_sat <= 1'b1;
                end else begin
                    r_seg <= r_seg + 1'b1;
                end
            end
            if (w_seg_xfer && c_ef)
                r_word_valid <= 1'b1;
            else if (w_fifo_wr)
                r_word_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fifo_wr)
            r_mem[r_wr_ptr] <= r_word;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_usage  <= '0;
        end else begin
            if (w_fifo_wr)
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            if (w_fifo_rd)
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            if (w_fifo_wr && !w_fifo_rd)
                r_usage <= r_usage + 1'b1;
            else if (!w_fifo_wr && w_fifo_rd)
                r_usage <= r_usage - 1'b1;
        end
    end

    // A mismatch resynchronises the expected value to the word just seen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pidx     <= '0;
            r_expected <= '0;
            r_ok_cnt   <= '0;
            r_err_cnt  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_pidx <= r_pidx + 3'd1;
            r_err  <= 1'b0;
            if (w_fifo_rd) begin
                if (w_rd_data == r_expected) begin
                    if (r_ok_cnt != 16'hFFFF)
                        r_ok_cnt <= r_ok_cnt + 16'd1;
                    r_expected <= r_expected + 1'b1;
                end else begin
                    if (r_err_cnt != 16'hFFFF)
                        r_err_cnt <= r_err_cnt + 16'd1;
                    r_err      <= 1'b1;
                    r_expected <= w_rd_data + 1'b1;
                end
            end
        end
    end

    assign usage   = r_usage;
    assign ok_cnt  = r_ok_cnt;
    assign err_cnt = r_err_cnt;
    assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sd_deser_fifo_check.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sd_deser_fifo_check
//  Brief    : Table, directed and randomized checks of sd_deser_fifo_check.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sd_deser_fifo_check;

    localparam int USZ  = 3;
    localparam int WMOD = 512;

    logic           clk;
    logic           reset;
    logic           c_srdy;
    logic           c_drdy;
    logic [3:0]     c_data;
    logic           c_ef;
    logic [7:0]     drdy_pat;
    logic [USZ-1:0] usage;
    logic [15:0]    ok_cnt;
    logic [15:0]    err_cnt;
    logic           err;

    sd_deser_fifo_check #(.PARA_WIDTH(9), .SER_WIDTH(4), .DEPTH(7)) dut (
        .clk      (clk),
        .reset    (reset),
        .c_srdy   (c_srdy),
        .c_drdy   (c_drdy),
        .c_data   (c_data),
        .c_ef     (c_ef),
        .drdy_pat (drdy_pat),
        .usage    (usage),
        .ok_cnt   (ok_cnt),
        .err_cnt  (err_cnt),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    int err_pulses;
    int usage_over;
    int mon_limit;

    always @(negedge clk) begin
        if (err === 1'b1)
            err_pulses++;
        if (int'(usage) > mon_limit)
            usage_over++;
    end

    typedef struct {
        logic [7:0] pat;
        int         base;
        int         n;
        int         exp_ok;
        int         exp_err;
        int         lim;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_seg(input logic [3:0] d, input logic ef);
        int t;
        @(negedge clk);
        c_srdy = 1'b1;
        c_data = d;
        c_ef   = ef;
        t = 0;
        while (c_drdy !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            check("drdy_timeout", 32'd0, 32'd1);
            c_srdy = 1'b0;
            return;
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        c_srdy = 1'b0;
        c_ef   = 1'b0;
    endtask

    // Segments past the third carry junk that must be discarded.
    task automatic send_word(input int w, input int nseg);
        for (int k = 0; k < nseg; k++) begin
            logic [3:0] d;
            d = (k < 3) ? 4'((w >> (4 * k)) & 15) : 4'($urandom_range(0, 15));
            send_seg(d, k == nseg - 1);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset  = 1'b0;
        c_srdy = 1'b0;
        c_ef   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_drain();
        int quiet;
        int t;
        quiet = 0;
        t = 0;
        idle();
        while (quiet < 3 && t < 5000) begin
            @(negedge clk);
            t++;
            if (usage == 0) quiet++;
            else quiet = 0;
        end
        if (t >= 5000)
            check("drain_timeout", 32'd0, 32'd1);
    endtask

    // Checker outcome derived from the sequence of reassembled words alone.
    function automatic void model(input int q[$], output int ok, output int er);
        int expv;
        ok = 0;
        er = 0;
        expv = 0;
        foreach (q[i]) begin
            if (q[i] == expv) begin
                ok++;
                expv = (expv + 1) % WMOD;
            end else begin
                er++;
                expv = (q[i] + 1) % WMOD;
            end
        end
    endfunction

    initial begin
        int p0;
        int u0;
        int m_ok;
        int m_err;
        int q[$];

        vecs[0] = '{8'hFF,   0, 100, 100, 0, 1};
        vecs[1] = '{8'hA5, 505,  11,  10, 1, 7};
        vecs[2] = '{8'h3C,   0,  20,  20, 0, 7};
        vecs[3] = '{8'h01,   7,   5,   4, 1, 7};

        checks = 0;
        errors = 0;
        err_pulses = 0;
        usage_over = 0;
        mon_limit = 7;
        reset = 1'b0;
        c_srdy = 1'b0;
        c_data = 4'h0;
        c_ef = 1'b0;
        drdy_pat = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_usage", 32'(usage), 32'd0);
        check("rst_ok_cnt", 32'(ok_cnt), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_c_drdy", 32'(c_drdy), 32'd1);

        for (int v = 0; v < 4; v++) begin
            apply_reset();
            drdy_pat = vecs[v].pat;
            mon_limit = vecs[v].lim;
            p0 = err_pulses;
            u0 = usage_over;
            for (int i = 0; i < vecs[v].n; i++)
                send_word((vecs[v].base + i) % WMOD, 3);
            wait_drain();
            check($sformatf("vec%0d_ok_cnt", v), 32'(ok_cnt), 32'(vecs[v].exp_ok));
            check($sformatf("vec%0d_err_cnt", v), 32'(err_cnt), 32'(vecs[v].exp_err));
            check($sformatf("vec%0d_err_pulses", v), 32'(err_pulses - p0), 32'(vecs[v].exp_err));
            check($sformatf("vec%0d_usage_limit", v), 32'(usage_over - u0), 32'd0);
            check($sformatf("vec%0d_usage_end", v), 32'(usage), 32'd0);
        end
        mon_limit = 7;

        // Backpressure: FIFO fills, eighth word parks in the deserializer.
        apply_reset();
        drdy_pat = 8'h00;
        for (int i = 0; i < 8; i++)
            send_word(i, 3);
        idle();
        repeat (3) @(negedge clk);
        check("full_usage", 32'(usage), 32'd7);
        check("full_c_drdy", 32'(c_drdy), 32'd0);
        check("full_ok_cnt", 32'(ok_cnt), 32'd0);
        drdy_pat = 8'hFF;
        send_word(8, 3);
        wait_drain();
        check("full_drain_ok", 32'(ok_cnt), 32'd9);
        check("full_drain_err", 32'(err_cnt), 32'd0);
        check("full_drain_usage", 32'(usage), 32'd0);

        // Sequence gap 1 -> 5.
        apply_reset();
        drdy_pat = 8'hFF;
        p0 = err_pulses;
        send_word(0, 3);
        send_word(1, 3);
        send_word(5, 3);
        send_word(6, 3);
        wait_drain();
        check("gap_ok", 32'(ok_cnt), 32'd3);
        check("gap_err", 32'(err_cnt), 32'd1);
        check("gap_pulses", 32'(err_pulses - p0), 32'd1);

        // Segment ordering, truncation, early ef and overflow segments.
        apply_reset();
        drdy_pat = 8'hFF;
        send_seg(4'h5, 1'b0);
        send_seg(4'hA, 1'b0);
        send_seg(4'h1, 1'b1);
        wait_drain();
        check("seg_1a5_ok", 32'(ok_cnt), 32'd0);
        check("seg_1a5_err", 32'(err_cnt), 32'd1);
        send_seg(4'h6, 1'b0);
        send_seg(4'hA, 1'b0);
        send_seg(4'hF, 1'b1);
        wait_drain();
        check("seg_1a6_trunc_ok", 32'(ok_cnt), 32'd1);
        send_seg(4'h3, 1'b1);
        wait_drain();
        check("seg_short_err", 32'(err_cnt), 32'd2);
        send_word(4, 3);
        wait_drain();
        check("seg_short_zero_ok", 32'(ok_cnt), 32'd2);
        send_seg(4'h5, 1'b0);
        send_seg(4'h0, 1'b0);
        send_seg(4'h0, 1'b0);
        send_seg(4'h7, 1'b0);
        send_seg(4'h9, 1'b1);
        wait_drain();
        check("seg_overflow_ok", 32'(ok_cnt), 32'd3);
        check("seg_overflow_err", 32'(err_cnt), 32'd2);

        // Asynchronous reset in the middle of a word.
        apply_reset();
        drdy_pat = 8'hFF;
        send_word(0, 3);
        wait_drain();
        drdy_pat = 8'h00;
        send_word(1, 3);
        send_seg(4'h2, 1'b0);
        send_seg(4'h0, 1'b0);
        @(negedge clk);
        check("pre_areset_usage", 32'(usage), 32'd1);
        #2;
        reset  = 1'b0;
        c_srdy = 1'b0;
        #1;
        check("areset_usage", 32'(usage), 32'd0);
        check("areset_ok", 32'(ok_cnt), 32'd0);
        check("areset_err", 32'(err_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        drdy_pat = 8'hFF;
        send_word(0, 3);
        wait_drain();
        check("post_areset_ok", 32'(ok_cnt), 32'd1);
        check("post_areset_err", 32'(err_cnt), 32'd0);

        // Randomized runs against the sequence model.
        for (int r = 0; r < 3; r++) begin
            int prev;
            apply_reset();
            drdy_pat = 8'($urandom_range(1, 255));
            p0 = err_pulses;
            u0 = usage_over;
            q.delete();
            prev = $urandom_range(0, WMOD - 1);
            for (int i = 0; i < 60; i++) begin
                int w;
                int ns;
                int sel;
                w = ($urandom_range(0, 9) < 8) ? (prev + 1) % WMOD : $urandom_range(0, WMOD - 1);
                prev = w;
                sel = $urandom_range(0, 9);
                ns = (sel == 0) ? 1 : (sel == 1) ? 2 : (sel == 2) ? 4 : (sel == 3) ? 5 : 3;
                send_word(w, ns);
                q.push_back((ns >= 3) ? w : (w & ((1 << (4 * ns)) - 1)));
                if ($urandom_range(0, 3) == 0) begin
                    idle();
                    repeat ($urandom_range(0, 6)) @(negedge clk);
                end
            end
            wait_drain();
            model(q, m_ok, m_err);
            check($sformatf("rand%0d_ok", r), 32'(ok_cnt), 32'(m_ok));
            check($sformatf("rand%0d_err", r), 32'(err_cnt), 32'(m_err));
            check($sformatf("rand%0d_pulses", r), 32'(err_pulses - p0), 32'(m_err));
            check($sformatf("rand%0d_usage_range", r), 32'(usage_over - u0), 32'd0);
            check($sformatf("rand%0d_usage_end", r), 32'(usage), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
